// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache for the IF stage.
//
// A hit returns the instruction combinationally in the same cycle. A miss
// drops cpu_ready and refills the whole line from backing memory, one word
// per req/ack handshake, in ascending offset order. A DONE bubble follows
// the refill, and then the lookup is repeated.
//
// Ports:
//   clock      system clock; all state changes on the rising edge
//   reset      synchronous, active-high
//   cpu_addr   word address of the requested instruction (PC)
//   cpu_data   instruction word; valid only while cpu_ready = 1
//   cpu_ready  lookup hit this cycle
//   flush      single-cycle pulse; invalidates every line
//   mem_req    refill word request; held until mem_ack
//   mem_addr   word address of the requested refill word
//   mem_ack    mem_data valid; consumes the current request
//   mem_data   refill data word
//
// state  | meaning
// IDLE   | lookup; hit serves the CPU, miss captures the line and starts a refill
// REFILL | burst of WORDS requests to memory, one word per ack
// DONE   | single bubble cycle before the lookup is repeated

module icache_direct #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;

    logic [31:0]      data_arr [LINES][WORDS];
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [LINES-1:0] valid;

    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic [OFF_W-1:0] cnt;
    logic             abort_fill;

    logic hit;
    logic start_fill;
    logic word_ack;
    logic fill_last;

    assign offset = cpu_addr[OFF_W-1:0];
    assign index  = cpu_addr[OFF_W+IDX_W-1:OFF_W];
    assign tag    = cpu_addr[31:OFF_W+IDX_W];

    assign hit       = valid[index] && (tag_arr[index] == tag);
    assign word_ack  = (state == REFILL) && mem_ack;
    assign fill_last = word_ack && (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are forced to zero outside the state that owns them, so that
    // cpu_data never exposes the unreset data array on a miss.
    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        cpu_data   = '0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        start_fill = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = hit;
                if (hit) begin
                    cpu_data = data_arr[index][offset];
                end else if (!flush) begin
                    start_fill = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_idx, cnt};
                if (fill_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers. A flush always wins over the end-of-burst valid set,
    // and a flush arriving mid-burst marks the line being filled as unusable.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid      <= '0;
            cnt        <= '0;
            abort_fill <= 1'b0;
            miss_idx   <= '0;
            miss_tag   <= '0;
        end else begin
            if (start_fill) begin
                miss_idx <= index;
                miss_tag <= tag;
                cnt      <= '0;
            end
            if (word_ack) begin
                cnt <= cnt + 1'b1;
            end
            if (fill_last && !abort_fill) begin
                valid[miss_idx] <= 1'b1;
            end
            if (flush) begin
                valid <= '0;
                if (state != IDLE) begin
                    abort_fill <= 1'b1;
                end
            end
            if (state == DONE) begin
                abort_fill <= 1'b0;
            end
        end
    end

    // Storage arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clock) begin
        if (!reset && word_ack) begin
            data_arr[miss_idx][cnt] <= mem_data;
            if (fill_last) begin
                tag_arr[miss_idx] <= miss_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed bench for icache_direct (LINES = 16, WORDS = 4).
// A behavioural memory answers each request after wait_k idle cycles with
// data = address + 0x100 and logs every acknowledged address.

module tb_icache_direct;

    logic        clock;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int          n_vec;
    int          n_err;
    int          wait_k;
    int          wcnt;
    logic [31:0] ack_log [$];

    icache_direct #(.LINES(16), .WORDS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model, evaluated 2 time units after each rising edge.
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        wcnt     = 0;
        forever begin
            @(posedge clock);
            #2;
            if (mem_req) begin
                if (wcnt >= wait_k) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_addr + 32'h100;
                    ack_log.push_back(mem_addr);
                    wcnt     = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt    = wcnt + 1;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Cycles from the current cycle until cpu_ready; -1 if it never comes.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        @(negedge clock);
        while (!cpu_ready && cyc < 100) begin
            tick();
            cyc++;
            @(negedge clock);
        end
        if (!cpu_ready) cyc = -1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        flush    = 1'b0;
        cpu_addr = '0;
        wait_k   = 0;
        tick();
        tick();
        @(negedge clock);
        n_vec++;
        if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", cpu_ready); end
        n_vec++;
        if (cpu_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", cpu_data); end
        n_vec++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_vec++;
        if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    endtask

    task automatic test_cold_miss();
        int cyc;
        tick();
        reset    = 1'b0;
        cpu_addr = 32'h5;
        ack_log.delete();
        wait_ready(cyc);
        n_vec++;
        if (cyc !== 6) begin n_err++; $display("FAIL cold_latency: got %0d expected 6", cyc); end
        n_vec++;
        if (cpu_data !== 32'h105) begin n_err++; $display("FAIL cold_data: got %h expected 00000105", cpu_data); end
        n_vec++;
        if (ack_log.size() !== 4) begin
            n_err++;
            $display("FAIL cold_ack_count: got %0d expected 4", ack_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (ack_log[i] !== 32'h4 + 32'(i)) begin
                    n_err++;
                    $display("FAIL cold_mem_addr[%0d]: got %h expected %h", i, ack_log[i], 32'h4 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_line_hit();
        for (int a = 4; a < 8; a++) begin
            tick();
            cpu_addr = 32'(a);
            @(negedge clock);
            n_vec++;
            if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL hit_ready[%0d]: got %b expected 1", a, cpu_ready); end
            n_vec++;
            if (cpu_data !== 32'h100 + 32'(a)) begin n_err++; $display("FAIL hit_data[%0d]: got %h expected %h", a, cpu_data, 32'h100 + 32'(a)); end
            n_vec++;
            if (mem_req !== 1'b0) begin n_err++; $display("FAIL hit_req[%0d]: got %b expected 0", a, mem_req); end
        end
    endtask

    task automatic test_conflict();
        int cyc;
        tick();
        cpu_addr = 32'h44;
        ack_log.delete();
        wait_ready(cyc);
        n_vec++;
        if (cyc !== 6) begin n_err++; $display("FAIL evict_latency: got %0d expected 6", cyc); end
        n_vec++;
        if (cpu_data !== 32'h144) begin n_err++; $display("FAIL evict_data: got %h expected 00000144", cpu_data); end
        n_vec++;
        if (ack_log.size() == 0 || ack_log[0] !== 32'h44) begin
            n_err++;
            $display("FAIL evict_first_addr: got %h expected 00000044", ack_log.size() == 0 ? 32'hx : ack_log[0]);
        end
        tick();
        cpu_addr = 32'h4;
        wait_ready(cyc);
        n_vec++;
        if (cyc !== 6) begin n_err++; $display("FAIL remiss_latency: got %0d expected 6", cyc); end
        n_vec++;
        if (cpu_data !== 32'h104) begin n_err++; $display("FAIL remiss_data: got %h expected 00000104", cpu_data); end
    endtask

    task automatic test_slow_memory();
        wait_k = 3;
        tick();
        cpu_addr = 32'h80;
        @(negedge clock);
        n_vec++;
        if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL slow_miss: got %b expected 0", cpu_ready); end
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                @(negedge clock);
                n_vec++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h80 + 32'(w)) begin
                    n_err++;
                    $display("FAIL slow_req[%0d.%0d]: got req=%b addr=%h expected req=1 addr=%h", w, j, mem_req, mem_addr, 32'h80 + 32'(w));
                end
            end
        end
        tick();
        @(negedge clock);
        n_vec++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            n_err++;
            $display("FAIL slow_done: got req=%b ready=%b expected 0 0", mem_req, cpu_ready);
        end
        tick();
        @(negedge clock);
        n_vec++;
        if (cpu_ready !== 1'b1 || cpu_data !== 32'h180) begin
            n_err++;
            $display("FAIL slow_hit: got ready=%b data=%h expected 1 00000180", cpu_ready, cpu_data);
        end
        wait_k = 0;
    endtask

    task automatic test_flush_refill();
        int cyc;
        tick();
        cpu_addr = 32'hC0;
        ack_log.delete();
        for (int c = 1; c <= 6; c++) begin
            tick();
            flush = (c == 2);
            @(negedge clock);
            if (c == 5) begin
                n_vec++;
                if (mem_req !== 1'b0) begin n_err++; $display("FAIL flushfill_done_req: got %b expected 0", mem_req); end
            end
        end
        flush = 1'b0;
        n_vec++;
        if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL flushfill_invalid: got %b expected 0", cpu_ready); end
        n_vec++;
        if (ack_log.size() !== 4) begin n_err++; $display("FAIL flushfill_ack_count: got %0d expected 4", ack_log.size()); end
        tick();
        @(negedge clock);
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hC0) begin
            n_err++;
            $display("FAIL flushfill_rerefill: got req=%b addr=%h expected 1 000000c0", mem_req, mem_addr);
        end
        tick();
        wait_ready(cyc);
        n_vec++;
        if (cyc !== 4) begin n_err++; $display("FAIL flushfill_latency: got %0d expected 4", cyc); end
        n_vec++;
        if (cpu_data !== 32'h1C0) begin n_err++; $display("FAIL flushfill_data: got %h expected 000001c0", cpu_data); end
    endtask

    task automatic test_flush_idle();
        int cyc;
        tick();
        cpu_addr = 32'h8;
        wait_ready(cyc);
        n_vec++;
        if (cyc !== 6) begin n_err++; $display("FAIL fidle_load: got %0d expected 6", cyc); end
        tick();
        flush = 1'b1;
        @(negedge clock);
        n_vec++;
        if (cpu_ready !== 1'b1 || cpu_data !== 32'h108) begin
            n_err++;
            $display("FAIL fidle_preflush: got ready=%b data=%h expected 1 00000108", cpu_ready, cpu_data);
        end
        tick();
        cpu_addr = 32'h100;
        @(negedge clock);
        n_vec++;
        if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL fidle_miss: got %b expected 0", cpu_ready); end
        tick();
        flush    = 1'b0;
        cpu_addr = 32'h8;
        @(negedge clock);
        n_vec++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fidle_no_fill: got req=%b ready=%b expected 0 0", mem_req, cpu_ready);
        end
        tick();
        @(negedge clock);
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_err++;
            $display("FAIL fidle_refill: got req=%b addr=%h expected 1 00000008", mem_req, mem_addr);
        end
        tick();
        wait_ready(cyc);
        n_vec++;
        if (cyc !== 4 || cpu_data !== 32'h108) begin
            n_err++;
            $display("FAIL fidle_reload: got cyc=%0d data=%h expected 4 00000108", cyc, cpu_data);
        end
    endtask

    task automatic test_reset_mid_refill();
        int cyc;
        tick();
        cpu_addr = 32'h200;
        tick();
        @(negedge clock);
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL rst_refill: got req=%b addr=%h expected 1 00000200", mem_req, mem_addr);
        end
        tick();
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_sync_hold: got %b expected 1", mem_req); end
        tick();
        @(negedge clock);
        n_vec++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || cpu_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_drop: got req=%b addr=%h ready=%b expected 0 0 0", mem_req, mem_addr, cpu_ready);
        end
        tick();
        reset    = 1'b0;
        cpu_addr = 32'h8;
        wait_ready(cyc);
        n_vec++;
        if (cyc !== 6 || cpu_data !== 32'h108) begin
            n_err++;
            $display("FAIL rst_remiss: got cyc=%0d data=%h expected 6 00000108", cyc, cpu_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_cold_miss();
        test_line_hit();
        test_conflict();
        test_slow_memory();
        test_flush_refill();
        test_flush_idle();
        test_reset_mid_refill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
